// File: rtl/wb_stage.sv
// Writeback pipeline register: picks ALU or extended load data, flags faulting loads.
// Optional retired-instruction counter is built when WB_RETIRE_CNT_EN is defined.
module wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            in_valid,
  input  logic            in_reg_write,
  input  logic [4:0]      in_rd,
  input  logic            in_mem_to_reg,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_mem_rdata,
  output logic            reg_write,
  output logic [4:0]      write_reg,
  output logic [XLEN-1:0] write_data,
  output logic            wb_valid,
  output logic            load_err
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [XLEN-1:0] retire_count
`endif
);

  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [XLEN-1:0] ld_data;
  logic            ld_fault;
  logic            err;
  logic            capture;

  logic            valid_q, valid_d;
  logic            rw_q, rw_d;
  logic            err_q, err_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;
`ifdef WB_RETIRE_CNT_EN
  logic [XLEN-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    case (in_addr_lo)
      2'd0:    lane_b = in_mem_rdata[7:0];
      2'd1:    lane_b = in_mem_rdata[15:8];
      2'd2:    lane_b = in_mem_rdata[23:16];
      default: lane_b = in_mem_rdata[31:24];
    endcase
    lane_h = in_addr_lo[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];

    ld_data  = in_mem_rdata;
    ld_fault = 1'b0;
    case (in_funct3)
      3'b000: ld_data = {{(XLEN-8){lane_b[7]}}, lane_b};
      3'b001: begin
        ld_data  = {{(XLEN-16){lane_h[15]}}, lane_h};
        ld_fault = in_addr_lo[0];
      end
      3'b010: ld_fault = (in_addr_lo != 2'd0);
      3'b100: ld_data = {{(XLEN-8){1'b0}}, lane_b};
      3'b101: begin
        ld_data  = {{(XLEN-16){1'b0}}, lane_h};
        ld_fault = in_addr_lo[0];
      end
      default: ld_fault = 1'b1;
    endcase

    // Faults only matter on the load path; ALU results ignore funct3/addr.
    err     = in_mem_to_reg & ld_fault;
    capture = in_valid & ~stall;

    valid_d = 1'b0;
    rw_d    = 1'b0;
    err_d   = 1'b0;
    rd_d    = rd_q;
    data_d  = data_q;
`ifdef WB_RETIRE_CNT_EN
    cnt_d   = cnt_q;
`endif
    if (capture) begin
      valid_d = 1'b1;
      rw_d    = in_reg_write & ~err & (in_rd != 5'd0);
      err_d   = err;
      rd_d    = in_rd;
      data_d  = in_mem_to_reg ? ld_data : in_alu_result;
`ifdef WB_RETIRE_CNT_EN
      if (!err) cnt_d = cnt_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 5'd0;
      data_q  <= '0;
`ifdef WB_RETIRE_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
`ifdef WB_RETIRE_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign wb_valid   = valid_q;
  assign reg_write  = rw_q;
  assign load_err   = err_q;
  assign write_reg  = rd_q;
  assign write_data = data_q;
`ifdef WB_RETIRE_CNT_EN
  assign retire_count = cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: driver pushes model expectations, monitor pops and compares.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, in_valid, in_reg_write, in_mem_to_reg;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result, in_mem_rdata;
  logic        reg_write, wb_valid, load_err;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] retire_count;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_mem_to_reg(in_mem_to_reg),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .wb_valid(wb_valid), .load_err(load_err)
`ifdef WB_RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

`ifndef WB_RETIRE_CNT_EN
  assign retire_count = 32'd0;
`endif

  typedef struct {
    bit          valid;
    bit          rw;
    bit          err;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          data_known;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          running = 1'b0;

  // Reference state: what the register file port should be showing.
  logic [4:0]  m_rd = '0;
  logic [31:0] m_data = '0;
  bit          m_known = 1'b1;
  logic [31:0] m_cnt = '0;
  bit          do_wrap = 1'b0;

  function automatic void model_load(input logic [2:0] f3, input logic [1:0] a,
                                     input logic [31:0] w, output logic [31:0] d,
                                     output bit err);
    int unsigned size = 1 << f3[1:0];
    longint unsigned m, v;
    d = w;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) begin
      err = 1'b1;
      return;
    end
    err = ((a % size) != 0);
    m = (64'd1 << (8 * size)) - 1;
    v = (longint'(w) >> (8 * a)) & m;
    if (!f3[2] && v[8*size-1]) v = v | ~m;
    d = v[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit st, input bit v, input bit rw,
                      input logic [4:0] rd, input bit m2r, input logic [2:0] f3,
                      input logic [1:0] a, input logic [31:0] alu, input logic [31:0] rdata);
    exp_t e;
    logic [31:0] ld;
    bit err;
    @(negedge clk);
    if (do_wrap) begin
`ifdef WB_RETIRE_CNT_EN
      dut.cnt_q = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
`endif
      do_wrap = 1'b0;
    end
    rst = r; stall = st; in_valid = v; in_reg_write = rw; in_rd = rd;
    in_mem_to_reg = m2r; in_funct3 = f3; in_addr_lo = a;
    in_alu_result = alu; in_mem_rdata = rdata;
    e.valid = 0; e.rw = 0; e.err = 0;
    if (r) begin
      m_rd = '0; m_data = '0; m_known = 1'b1; m_cnt = '0;
    end else if (v && !st) begin
      model_load(f3, a, rdata, ld, err);
      err = err && m2r;
      e.valid = 1;
      e.err = err;
      e.rw = rw && !err && (rd != 0);
      m_rd = rd;
      m_data = m2r ? ld : alu;
      m_known = !err;
      if (!err) m_cnt = m_cnt + 1;
    end
    e.rd = m_rd; e.data = m_data; e.data_known = m_known; e.cnt = m_cnt;
    sb_q.push_back(e);
    running = 1'b1;
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] val);
    step(0, 0, 1, 1, rd, 0, 3'b000, 2'd0, val, 32'h0);
  endtask

  task automatic load_op(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] a);
    step(0, 0, 1, 1, rd, 1, f3, a, 32'h1234_5678, 32'h8081_F27F);
  endtask

  // Monitor: one scoreboard entry per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (running) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
        end else begin
          e = sb_q.pop_front();
          chk("wb_valid", {31'd0, wb_valid}, {31'd0, e.valid});
          chk("reg_write", {31'd0, reg_write}, {31'd0, e.rw});
          chk("load_err", {31'd0, load_err}, {31'd0, e.err});
          chk("write_reg", {27'd0, write_reg}, {27'd0, e.rd});
          if (e.data_known) chk("write_data", write_data, e.data);
`ifdef WB_RETIRE_CNT_EN
          chk("retire_count", retire_count, e.cnt);
`endif
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; stall = 0; in_valid = 0; in_reg_write = 0; in_rd = 0;
    in_mem_to_reg = 0; in_funct3 = 0; in_addr_lo = 0; in_alu_result = 0; in_mem_rdata = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 5'd3, 0, 0, 0, 32'h1111_1111, 0);
    alu_op(5'd5, 32'hDEAD_BEEF);
    load_op(5'd1, 3'b000, 2'd0);
    load_op(5'd2, 3'b000, 2'd3);
    load_op(5'd3, 3'b100, 2'd3);
    load_op(5'd4, 3'b001, 2'd2);
    load_op(5'd6, 3'b101, 2'd0);
    load_op(5'd7, 3'b010, 2'd0);
    load_op(5'd8, 3'b010, 2'd2);
    load_op(5'd9, 3'b001, 2'd1);
    load_op(5'd10, 3'b111, 2'd0);
    alu_op(5'd0, 32'h0000_00AA);
    step(0, 1, 1, 1, 5'd11, 0, 0, 0, 32'h5555_5555, 0);
    alu_op(5'd11, 32'h5555_5555);
    alu_op(5'd12, 32'h0000_0001);
    step(1, 0, 1, 1, 5'd13, 0, 0, 0, 32'h0000_0002, 0);
    alu_op(5'd14, 32'h0000_0003);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_wrap = 1'b1;
    alu_op(5'd15, 32'hCAFE_F00D);
    alu_op(5'd16, 32'h0BAD_F00D);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
           5'($urandom_range(0, 31)), $urandom_range(0, 1),
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           $urandom, $urandom);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    running = 1'b0;
    if (sb_q.size() != 0) chk("sb_leftover", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
